// File: rtl/cpu_opponent.sv
`default_nettype none
// ============================================================================
// Module      : cpu_opponent
// Description : Computer-controlled paddle player. Watches the ball's hit
//               window and produces a synthetic button level after a
//               skill-dependent pseudo-random reaction delay. It sometimes
//               deliberately skips a window.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_opponent #(
    parameter int          TICK_DIV    = 100000,
    parameter int          PRESS_TICKS = 20,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_enable,
    input  logic       i_hittable,
    input  logic       i_start_game,
    input  logic [1:0] i_skill,
    output logic       o_press,
    output logic       o_busy,
    output logic       o_missed
);

    localparam int             TW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int             PW         = (PRESS_TICKS > 2) ? $clog2(PRESS_TICKS) : 1;
    localparam logic [TW-1:0]  TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  PRESS_LOAD = PW'(PRESS_TICKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_DELAY    = 3'd2,
        ST_PRESS    = 3'd3,
        ST_COOLDOWN = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_tick_cnt;
    logic [15:0]   r_lfsr;
    logic          r_hit_q;
    logic          r_hit_d;
    logic [6:0]    r_delay_cnt;
    logic [6:0]    w_delay_nxt;
    logic [PW-1:0] r_press_cnt;
    logic [PW-1:0] w_press_cnt_nxt;
    logic          r_cool_ok;
    logic          w_cool_nxt;
    logic          w_missed_nxt;
    logic          r_press;
    logic          r_busy;
    logic          r_missed;

    logic          w_tick;
    logic          w_rise;
    logic [3:0]    w_miss_thr;
    logic [6:0]    w_base;

    assign w_tick = (r_tick_cnt == TICK_LAST);
    assign w_rise = r_hit_q & ~r_hit_d;

    // Free-running reaction-tick divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1; steps every clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    // Register the hit window once, then keep one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_q <= 1'b0;
            r_hit_d <= 1'b0;
        end else begin
            r_hit_q <= i_hittable;
            r_hit_d <= r_hit_q;
        end
    end

    // Skill tables: stronger players miss less often and react faster.
    always_comb begin
        w_miss_thr = 4'd0;
        w_base     = 7'd4;
        case (i_skill)
            2'd0: begin w_miss_thr = 4'd6; w_base = 7'd40; end
            2'd1: begin w_miss_thr = 4'd3; w_base = 7'd25; end
            2'd2: begin w_miss_thr = 4'd1; w_base = 7'd12; end
            default: begin w_miss_thr = 4'd0; w_base = 7'd4; end
        endcase
    end

    // Next-state logic; enable and start_game override whatever the FSM is doing.
    always_comb begin
        w_state_nxt     = r_state;
        w_delay_nxt     = r_delay_cnt;
        w_press_cnt_nxt = r_press_cnt;
        w_cool_nxt      = r_cool_ok;
        w_missed_nxt    = 1'b0;
        if (!i_enable) begin
            w_state_nxt = ST_IDLE;
            w_delay_nxt = '0;
        end else if (i_start_game && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_ARMED;
            w_delay_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_rise) begin
                        if (r_lfsr[15:12] < w_miss_thr) begin
                            w_missed_nxt = 1'b1;
                            w_cool_nxt   = 1'b0;
                            w_state_nxt  = ST_COOLDOWN;
                        end else begin
                            w_delay_nxt = w_base + {3'b000, r_lfsr[3:0]};
                            w_state_nxt = ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    // Window closed before we reacted: give up on this one.
                    if (!r_hit_q) begin
                        w_missed_nxt = 1'b1;
                        w_cool_nxt   = 1'b0;
                        w_state_nxt  = ST_COOLDOWN;
                    end else if (w_tick) begin
                        if (r_delay_cnt == 7'd0) begin
                            w_press_cnt_nxt = PRESS_LOAD;
                            w_state_nxt     = ST_PRESS;
                        end else begin
                            w_delay_nxt = r_delay_cnt - 7'd1;
                        end
                    end
                end
                ST_PRESS: begin
                    if (w_tick) begin
                        if (r_press_cnt == '0) begin
                            w_cool_nxt  = 1'b0;
                            w_state_nxt = ST_COOLDOWN;
                        end else begin
                            w_press_cnt_nxt = r_press_cnt - 1'b1;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    // Re-arm only after the window has been low across a whole tick.
                    if (r_hit_q) begin
                        w_cool_nxt = 1'b0;
                    end else if (w_tick) begin
                        if (r_cool_ok) begin
                            w_state_nxt = ST_ARMED;
                        end else begin
                            w_cool_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_delay_cnt <= '0;
            r_press_cnt <= '0;
            r_cool_ok   <= 1'b0;
            r_press     <= 1'b0;
            r_busy      <= 1'b0;
            r_missed    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_delay_cnt <= w_delay_nxt;
            r_press_cnt <= w_press_cnt_nxt;
            r_cool_ok   <= w_cool_nxt;
            r_press     <= (w_state_nxt == ST_PRESS);
            r_busy      <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_ARMED);
            r_missed    <= w_missed_nxt;
        end
    end

    assign o_press  = r_press;
    assign o_busy   = r_busy;
    assign o_missed = r_missed;

endmodule
`default_nettype wire
